// File: rtl/bsg_cache_prefetch_issue.sv
// bsg_cache_prefetch_issue
//   Issue stage for the bsg_cache stream prefetcher. Prefetch address pulses
//   are block-aligned. A pulse is discarded when it hits a queued block, the
//   in-flight block or a recently issued block, when the queue is full, or
//   when a flush is in progress. Addresses that survive wait in a FIFO. One
//   address at a time is issued as a block DMA read, and only while the
//   cache's own miss DMA is idle. Each returned word goes out registered to
//   the prefetch buffer.
// Ports:
//   clk_i, reset_n_i           clock, async active-low reset
//   pf_v_i, pf_addr_i, flush_i prefetch address pulse, queue/history flush
//   drop_o, queue_count_o      discard pulse (one cycle late), queue occupancy
//   dma_busy_i                 miss DMA active; prefetch waits while it is high
//   dma_req_*                  block read request handshake
//   dma_data_*                 returned word stream
//   fill_*                     registered fill stream to the prefetch buffer
module bsg_cache_prefetch_issue #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int queue_els_p           = 4,
  parameter int history_els_p         = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     pf_v_i,
  input  logic [addr_width_p-1:0]                  pf_addr_i,
  input  logic                                     flush_i,
  output logic                                     drop_o,
  output logic [$clog2(queue_els_p):0]             queue_count_o,
  input  logic                                     dma_busy_i,
  output logic                                     dma_req_v_o,
  output logic [addr_width_p-1:0]                  dma_req_addr_o,
  input  logic                                     dma_req_ready_i,
  input  logic                                     dma_data_v_i,
  input  logic [data_width_p-1:0]                  dma_data_i,
  output logic                                     dma_data_ready_o,
  output logic                                     fill_v_o,
  output logic [addr_width_p-1:0]                  fill_addr_o,
  output logic [$clog2(block_size_in_words_p)-1:0] fill_word_idx_o,
  output logic [data_width_p-1:0]                  fill_data_o,
  output logic                                     fill_last_o
);

  localparam int block_bytes_lp = block_size_in_words_p * data_width_p / 8;
  localparam int off_w_lp       = $clog2(block_bytes_lp);
  localparam int qptr_w_lp      = $clog2(queue_els_p);
  localparam int cnt_w_lp       = qptr_w_lp + 1;
  localparam int widx_w_lp      = $clog2(block_size_in_words_p);
  localparam int hptr_w_lp      = (history_els_p > 1) ? $clog2(history_els_p) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2} state_e;

  state_e                  state_r, state_s;
  logic [addr_width_p-1:0] queue_r [queue_els_p];
  logic [qptr_w_lp-1:0]    head_r, tail_r;
  logic [cnt_w_lp-1:0]     count_r;
  logic [addr_width_p-1:0] hist_addr_r [history_els_p];
  logic [history_els_p-1:0] hist_v_r;
  logic [hptr_w_lp-1:0]    hist_ptr_r;
  logic [addr_width_p-1:0] inflight_r;
  logic                    in_queue_r;
  logic [widx_w_lp-1:0]    word_cnt_r;
  logic                    drop_r, req_v_r, data_ready_r;
  logic                    fill_v_r, fill_last_r;
  logic [addr_width_p-1:0] fill_addr_r;
  logic [widx_w_lp-1:0]    fill_idx_r;
  logic [data_width_p-1:0] fill_data_r;

  logic [addr_width_p-1:0] aligned_s;
  logic hit_s, full_s, drop_s, push_s, hs_s, pop_s, accept_s, last_s;

  // Entry idx is live when it lies within count entries from the head (modulo depth).
  function automatic logic entry_live(input logic [qptr_w_lp-1:0] idx,
                                      input logic [qptr_w_lp-1:0] head,
                                      input logic [cnt_w_lp-1:0]  count);
    logic [qptr_w_lp-1:0] rel;
    rel = idx - head;
    return ({1'b0, rel} < count);
  endfunction

  assign aligned_s = {pf_addr_i[addr_width_p-1:off_w_lp], {off_w_lp{1'b0}}};
  assign full_s    = (count_r == cnt_w_lp'(queue_els_p));
  assign drop_s    = pf_v_i & (hit_s | full_s | flush_i);
  assign push_s    = pf_v_i & ~drop_s;
  assign hs_s      = (state_r == REQ) & dma_req_ready_i;
  // The in-flight block leaves the queue on handshake, unless a flush already emptied it.
  assign pop_s     = hs_s & in_queue_r & ~flush_i;
  assign accept_s  = (state_r == RECV) & dma_data_v_i;
  assign last_s    = accept_s & (word_cnt_r == widx_w_lp'(block_size_in_words_p - 1));

  // Duplicate detection against live queue entries, the in-flight block and history.
  always_comb begin
    hit_s = (state_r != IDLE) & (inflight_r == aligned_s);
    for (int i = 0; i < queue_els_p; i++) begin
      hit_s = hit_s | (entry_live(qptr_w_lp'(i), head_r, count_r) & (queue_r[i] == aligned_s));
    end
    for (int i = 0; i < history_els_p; i++) begin
      hit_s = hit_s | (hist_v_r[i] & (hist_addr_r[i] == aligned_s));
    end
  end

  // Issue FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if ((count_r != {cnt_w_lp{1'b0}}) && !dma_busy_i) state_s = REQ;
        else                                                state_s = IDLE;
      end
      REQ: begin
        if (dma_req_ready_i) state_s = RECV;
        else                 state_s = REQ;
      end
      RECV: begin
        if (last_s) state_s = IDLE;
        else        state_s = RECV;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and the handshake flags decoded from the next state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      req_v_r      <= 1'b0;
      data_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_v_r      <= (state_s == REQ);
      data_ready_r <= (state_s == RECV);
    end
  end

  // Pending-request FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < queue_els_p; i++) queue_r[i] <= {addr_width_p{1'b0}};
      head_r  <= {qptr_w_lp{1'b0}};
      tail_r  <= {qptr_w_lp{1'b0}};
      count_r <= {cnt_w_lp{1'b0}};
    end else if (flush_i) begin
      head_r  <= {qptr_w_lp{1'b0}};
      tail_r  <= {qptr_w_lp{1'b0}};
      count_r <= {cnt_w_lp{1'b0}};
    end else begin
      if (push_s) begin
        queue_r[tail_r] <= aligned_s;
        tail_r          <= tail_r + qptr_w_lp'(1);
      end
      if (pop_s) head_r <= head_r + qptr_w_lp'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Recently-issued block history, filled round-robin on each handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < history_els_p; i++) hist_addr_r[i] <= {addr_width_p{1'b0}};
      hist_v_r   <= {history_els_p{1'b0}};
      hist_ptr_r <= {hptr_w_lp{1'b0}};
    end else begin
      if (flush_i) hist_v_r <= {history_els_p{1'b0}};
      // A handshake coinciding with a flush still records the block being fetched.
      if (hs_s) begin
        hist_addr_r[hist_ptr_r] <= inflight_r;
        hist_v_r[hist_ptr_r]    <= 1'b1;
        if (hist_ptr_r == hptr_w_lp'(history_els_p - 1)) hist_ptr_r <= {hptr_w_lp{1'b0}};
        else                                              hist_ptr_r <= hist_ptr_r + hptr_w_lp'(1);
      end
    end
  end

  // In-flight block address and the word counter of the current transfer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inflight_r <= {addr_width_p{1'b0}};
      in_queue_r <= 1'b0;
      word_cnt_r <= {widx_w_lp{1'b0}};
    end else begin
      if ((state_r == IDLE) && (state_s == REQ)) begin
        inflight_r <= queue_r[head_r];
        in_queue_r <= ~flush_i;
      end else if (flush_i) begin
        in_queue_r <= 1'b0;
      end
      if (hs_s)          word_cnt_r <= {widx_w_lp{1'b0}};
      else if (accept_s) word_cnt_r <= word_cnt_r + widx_w_lp'(1);
    end
  end

  // Registered drop pulse and fill stream.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_r      <= 1'b0;
      fill_v_r    <= 1'b0;
      fill_last_r <= 1'b0;
      fill_addr_r <= {addr_width_p{1'b0}};
      fill_idx_r  <= {widx_w_lp{1'b0}};
      fill_data_r <= {data_width_p{1'b0}};
    end else begin
      drop_r      <= drop_s;
      fill_v_r    <= accept_s;
      fill_last_r <= last_s;
      if (accept_s) begin
        fill_addr_r <= inflight_r;
        fill_idx_r  <= word_cnt_r;
        fill_data_r <= dma_data_i;
      end
    end
  end

  assign drop_o           = drop_r;
  assign queue_count_o    = count_r;
  assign dma_req_v_o      = req_v_r;
  assign dma_req_addr_o   = inflight_r;
  assign dma_data_ready_o = data_ready_r;
  assign fill_v_o         = fill_v_r;
  assign fill_addr_o      = fill_addr_r;
  assign fill_word_idx_o  = fill_idx_r;
  assign fill_data_o      = fill_data_r;
  assign fill_last_o      = fill_last_r;

endmodule

// File: doc/bsg_cache_prefetch_issue.md
# bsg_cache_prefetch_issue

Downstream issue stage for the stream prefetcher inside bsg_cache. It accepts single-cycle prefetch address pulses, block-aligns them and drops duplicates and overflow. Surviving addresses are queued and issued as block-sized DMA reads whenever the cache's own miss DMA is idle. Returned words are streamed, registered, to the prefetch buffer.

## Interface
Parameters:
- addr_width_p, 32, byte-address width
- data_width_p, 32, DMA word width (bits)
- block_size_in_words_p, 8, words per cache block (power of 2, ≥2)
- queue_els_p, 4, pending-request FIFO depth (power of 2)
- history_els_p, 4, recently-issued block filter entries

Ports (one clock; reset asynchronous, active-low):
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- pf_v_i  in  1  prefetch address valid (pulse, no backpressure)
- pf_addr_i  in  addr_width_p  prefetch byte address
- flush_i  in  1  clear queue and history
- drop_o  out  1  registered pulse: previous-cycle pf_v_i was discarded
- queue_count_o  out  $clog2(queue_els_p)+1  valid queue entries
- dma_busy_i  in  1  cache miss DMA active (has priority)
- dma_req_v_o  out  1  prefetch DMA read request valid
- dma_req_addr_o  out  addr_width_p  block-aligned request address
- dma_req_ready_i  in  1  DMA accepts request
- dma_data_v_i  in  1  return word valid
- dma_data_i  in  data_width_p  return word
- dma_data_ready_o  out  1  issue stage accepts return word
- fill_v_o  out  1  fill word valid to prefetch buffer
- fill_addr_o  out  addr_width_p  block address of current fill
- fill_word_idx_o  out  $clog2(block_size_in_words_p)  word index within block
- fill_data_o  out  data_width_p  fill word
- fill_last_o  out  1  final word of block

## Operation
- Alignment: block bytes B = block_size_in_words_p*data_width_p/8. Aligned address = pf_addr_i with the low $clog2(B) bits zeroed.
- Input filter on pf_v_i. The request is dropped when any of the following holds:
  - the aligned address matches a valid queue entry, the in-flight block (REQ/RECV), or a valid history entry;
  - queue count == queue_els_p, evaluated on the registered count before any same-cycle pop;
  - flush_i is high.
- Otherwise the aligned address is pushed at the FIFO tail.
- FSM:
  - IDLE: if queue non-empty and !dma_busy_i, latch head into in-flight register, go to REQ.
  - REQ: dma_req_v_o=1, dma_req_addr_o=in-flight. Once asserted, valid is held regardless of dma_busy_i. On dma_req_ready_i: pop head, write in-flight address into history (round-robin slot), clear word counter, go to RECV.
  - RECV: dma_data_ready_o=1. Each accepted word increments the counter. On the word with counter == block_size_in_words_p-1, go to IDLE.
- Fill output is registered. The word accepted in cycle j appears in cycle j+1 with:
  - fill_v_o=1
  - fill_data_o = the word
  - fill_word_idx_o = counter value at acceptance
  - fill_addr_o = in-flight address
  - fill_last_o = 1 on the final word
- flush_i clears queue (count→0) and all history valid bits. It does not abort REQ/RECV: an in-flight request/transfer completes normally.
- queue_count_o is the registered count after the cycle's push/pop/flush. A simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo queue_els_p.

## Timing
- Reset values: all outputs 0, state IDLE, queue empty, history invalid, counter 0.
- Reset asserted mid-transfer returns to IDLE immediately; the partial block is abandoned with no fill_last_o.
- pf_v_i in cycle 0 (empty queue, IDLE, dma_busy_i=0): queue_count_o=1 in cycle 1, dma_req_v_o=1 in cycle 2.
- drop_o is asserted in cycle t+1 for a dropped pf_v_i in cycle t.
- Handshake in cycle k: dma_req_v_o=0 and dma_data_ready_o=1 from cycle k+1.
- Last word accepted in cycle j: fill_last_o in j+1, state IDLE in j+1, next dma_req_v_o no earlier than j+2.
- dma_busy_i is sampled only in IDLE.

## Test plan
- Single request: pf_addr_i=0x1004 at cycle 0 → dma_req_v_o with addr 0x1000 at cycle 2. Ready at cycle 2 and 8 words 0xA0..0xA7 on consecutive cycles → fill_v_o 8 cycles, idx 0..7, fill_addr_o=0x1000, fill_last_o with 0xA7.
- Dedup: 0x2000, 0x2010, 0x2000 on consecutive cycles while dma_busy_i=1 → queue_count_o=1, drop_o pulses twice. After issue, 0x2008 again → dropped via history.
- Overflow: dma_busy_i=1, push 5 distinct blocks 0x0,0x20,0x40,0x60,0x80 → count 4, fifth dropped. Release busy → requests issued in FIFO order 0x0..0x60.
- Busy priority: queue holds 0x300, dma_busy_i=1 for 10 cycles → no request. Busy falls → dma_req_v_o 1 cycle later. Raising busy during REQ keeps dma_req_v_o high until ready.
- Flush mid-transfer: flush_i in RECV with 2 queued → count 0, current block completes with fill_last_o. Re-pushing the completed address is accepted.
- Async reset: assert reset_n_i low during word 3 of a transfer → all outputs 0 immediately. After release, a new pf_v_i issues normally.
